// File: rtl/piso_pkg.sv
// ============================================================================
// piso_pkg : shared types and helpers for the PISO serializer
// Rev 1.0
// ============================================================================
`default_nettype none

package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    // Bit-counter width; callers use it as CNT_W = cnt_width(WIDTH).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// piso_serializer : valid/ready parallel-in, ser_en-paced serial-out shifter
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             final_bit;
    logic             accept;

`ifdef PISO_PARITY_EN
    logic parity_q, parity_d;
    assign final_bit = (state_q == PARITY);
`else
    assign final_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif

    assign s_ready = !rst && ((state_q == IDLE) || (final_bit && ser_en));
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_d = accept ? ^s_data : parity_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (ser_en && (cnt_q == LAST_CNT)) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (ser_en) state_d = accept ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // A new word on the final-bit edge overrides the frame-end clear.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shreg_d = s_data;
            cnt_d   = '0;
        end else if (final_bit && ser_en) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if ((state_q == SHIFT) && ser_en) begin
            shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = (cnt_q == LAST_CNT) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    assign done_d = final_bit && ser_en;
    assign done   = done_q;

    always_comb begin
        ser_out   = IDLE_LEVEL;
        ser_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            SHIFT: begin
                ser_out   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
                ser_valid = 1'b1;
                busy      = 1'b1;
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                ser_out   = parity_q;
                ser_valid = 1'b1;
                busy      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire
